// File: rtl/fadd_stream_collector.sv
// fadd_stream_collector
// Valid/ready front end and result collector for a pipelined float adder.
// Operands pass straight through to the adder. A shadow valid/tag pipeline
// follows each operation through the adder. Results are captured with their
// tags into a small FIFO. When the FIFO is full, the adder enable is dropped so
// that no result is ever lost.

module fadd_stream_collector #(
    parameter int LAT   = 3,
    parameter int TAGW  = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic                       in_sub,
    input  logic [1:0]                 in_rm,
    input  logic [TAGW-1:0]            in_tag,
    output logic [31:0]                fa_a,
    output logic [31:0]                fa_b,
    output logic                       fa_sub,
    output logic [1:0]                 fa_rm,
    output logic                       fa_e,
    input  logic [31:0]                fa_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_s,
    output logic [TAGW-1:0]            out_tag,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [LAT-1:0]  v_q;
    logic [TAGW-1:0] t_q [LAT];

    logic [31:0]     mem_s_q [DEPTH];
    logic [TAGW-1:0] mem_t_q [DEPTH];

    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;

    logic full;
    logic accept;
    logic push;
    logic pop;

    assign fa_a   = in_a;
    assign fa_b   = in_b;
    assign fa_sub = in_sub;
    assign fa_rm  = in_rm;

    // full comes only from registered occupancy, so out_ready never reaches
    // fa_e combinationally. A stall therefore releases one cycle after the pop.
    assign full      = (count_q == DEPTH_C);
    assign fa_e      = !(v_q[LAT-1] && full);
    assign in_ready  = fa_e;
    assign accept    = in_valid && in_ready;
    assign push      = fa_e && v_q[LAT-1];
    assign pop       = out_valid && out_ready;

    assign out_valid = (count_q != '0);
    assign out_s     = mem_s_q[rd_q];
    assign out_tag   = mem_t_q[rd_q];
    assign busy      = (|v_q) || (count_q != '0);
    assign count     = count_q;

    // Shadow valid bits advance in lock-step with the adder pipeline.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            v_q <= '0;
        end else if (fa_e) begin
            v_q <= (v_q << 1) | LAT'(accept);
        end
    end

    // Shadow tags. Only their paired valid bit gives them meaning, so they are not reset.
    always_ff @(posedge clk) begin
        if (fa_e) begin
            t_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                t_q[i] <= t_q[i-1];
            end
        end
    end

    // Result storage: capture the adder output with its tag on each push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_s_q[wr_q] <= fa_s;
            mem_t_q[wr_q] <= t_q[LAT-1];
        end
    end

    // Next-state logic for the pointers and occupancy.
    always_comb begin
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        rd_d    = pop  ? rd_q + PW'(1) : rd_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers. Reset takes priority over push and pop.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/fadd_stream_collector.md
# fadd_stream_collector

Valid/ready front-end and result collector for `pipelined_fadder`. Accepts tagged operand pairs, drives the adder's operand and enable pins, tracks each operation through the adder pipeline with a shadow valid/tag shift register, and captures each result with its tag into an output FIFO. When the FIFO is full it stalls the adder through its enable pin, so results are never dropped.

## Interface
- `LAT`, 3: adder pipeline registers. Operands presented in cycle c produce `fa_s` in cycle c+LAT, counting only cycles with `fa_e`=1.
- `TAGW`, 4: tag width.
- `DEPTH`, 8: output FIFO entries, power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `clrn`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  pair accepted this cycle when `in_valid`=1.
- `in_a`, `in_b`  in  32 each  IEEE-754 single operands.
- `in_sub`  in  1  1 = a−b.
- `in_rm`  in  2  rounding mode, passed through unchanged.
- `in_tag`  in  TAGW  caller tag.
- `fa_a`, `fa_b`  out  32 each  to adder `a`, `b`.
- `fa_sub`  out  1  to adder `sub`.
- `fa_rm`  out  2  to adder `rm`.
- `fa_e`  out  1  to adder `e`, the pipeline enable.
- `fa_s`  in  32  from adder `s`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_s`  out  32  result at FIFO head.
- `out_tag`  out  TAGW  tag at FIFO head.
- `busy`  out  1  any op in the shadow pipeline or FIFO.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Operand pins are combinational pass-throughs: `fa_a`=`in_a`, `fa_b`=`in_b`, `fa_sub`=`in_sub`, `fa_rm`=`in_rm`. When `in_valid`=0 the adder processes a bubble whose result is ignored.
- `full` = (`count`==DEPTH), a registered value.
- `fa_e` = !(`v[LAT-1]` && `full`).
- `in_ready` = `fa_e`.
- Accept = `in_valid` && `in_ready`.
- Shadow pipeline: `v[0..LAT-1]` and `t[0..LAT-1]`. On an edge with `fa_e`=1:
  - `v[0]` ← accept, `t[0]` ← `in_tag`;
  - `v[i]` ← `v[i-1]`, `t[i]` ← `t[i-1]`.
  - With `fa_e`=0 the shadow pipeline and the adder both hold.
- Push = `fa_e` && `v[LAT-1]`. Writes {`fa_s`, `t[LAT-1]`} at the write pointer. By construction a push never occurs while `full`.
- Pop = `out_valid` && `out_ready`. Advances the read pointer.
- `out_valid` = (`count`≠0). `out_s` and `out_tag` are read from the read-pointer entry.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `busy` = |`v` || (`count`≠0).
- Results leave in issue order; tags are not reordered or checked.
- Reset (`clrn`=0 at an edge):
  - clears `v`, both pointers and `count`;
  - all in-flight operations are discarded;
  - outputs after reset: `out_valid`=0, `count`=0, `busy`=0, `fa_e`=1, `in_ready`=1.
  - `out_s` and `out_tag` are don't-care.
  - Reset overrides a push or pop in the same cycle.
- `clrn` is also wired to the adder. The block makes no assumption about the adder's internal reset style.

## Timing
- Accept in cycle c with no stalls gives `fa_s` valid in cycle c+LAT, push at the end of c+LAT, and `out_valid`=1 in cycle c+LAT+1. Default latency is 4 cycles.
- Throughput is one op per cycle while the FIFO is not full.
- Stall entry: cycle where `v[LAT-1]`=1 and `full`=1 gives `fa_e`=0 and `in_ready`=0 in that same cycle.
- Stall exit: a pop at the end of cycle d makes `full`=0 in d+1, so `fa_e`=1 in d+1.
  - This gives a one-cycle bubble versus a combinational path. That is intended: there is no path from `out_ready` to `fa_e`.
- `fa_s` must be sampled only in push cycles. During a stall it is held by the adder.

## Test plan
- Reset, then a single op: accept `in_a`=3f800000, `in_b`=3f800000, `in_sub`=0, `in_rm`=0, `in_tag`=5 in cycle 0 → `out_valid`=1 in cycle 4 with `out_s`=40000000, `out_tag`=5, and `busy` falls after the pop.
- Back-to-back: 8 ops on consecutive cycles with tags 0..7, `out_ready`=1 → `out_valid` on cycles 4..11, tags 0..7 in order, and `in_ready` never drops.
- Backpressure: `out_ready`=0 while 12 ops are streamed → `count` reaches 8, then `fa_e`=`in_ready`=0 with `v[LAT-1]`=1. With `out_ready`=1 all 12 results drain in order with no loss or duplication, including across pointer wrap.
- Simultaneous push and pop at `count`=3 → `count` stays 3 and data order is preserved.
- Special values: 7f800000+7f800000 → 7f800000. The same operands with `in_sub`=1 → the adder's NaN, passed through unaltered with the correct tag.
- Reset mid-operation: `clrn`=0 with 3 ops in flight and 2 in the FIFO → next cycle `out_valid`=0, `count`=0, `busy`=0, and no stale result appears afterwards.
